// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants and entry-type encodings for the reorder buffer.
package reorder_buffer_pkg;

    localparam int unsigned ROB_WIDTH_BIT_DEF = 3;
    localparam int unsigned XLEN              = 32;
    localparam int unsigned REG_ID_W          = 5;

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'd0,
        ROB_TYPE_STORE  = 2'd1,
        ROB_TYPE_BRANCH = 2'd2,
        ROB_TYPE_EXIT   = 2'd3
    } rob_type_e;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates on issue, captures CDB results,
// retires the head one per cycle, answers operand queries and flushes on mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_valid,
    input  logic [1:0]               issue_type,
    input  logic [REG_ID_W-1:0]      issue_rd,
    input  logic                     issue_pred_jump,
    input  logic [XLEN-1:0]          issue_alt_pc,
    output logic                     rob_full,
    output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
    input  logic                     wb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] wb_rob_id,
    input  logic [XLEN-1:0]          wb_value,
    input  logic                     wb_real_jump,
    input  logic [ROB_WIDTH_BIT-1:0] get_rob_id1,
    input  logic [ROB_WIDTH_BIT-1:0] get_rob_id2,
    output logic                     rob_value1_ready,
    output logic [XLEN-1:0]          rob_value1,
    output logic                     rob_value2_ready,
    output logic [XLEN-1:0]          rob_value2,
    output logic [REG_ID_W-1:0]      set_reg_id,
    output logic [XLEN-1:0]          set_val,
    output logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id,
    output logic                     commit_store,
    output logic [ROB_WIDTH_BIT-1:0] commit_store_rob_id,
    output logic                     rob_clear,
    output logic [XLEN-1:0]          correct_pc,
    output logic                     halt
);

    localparam int unsigned DEPTH = 1 << ROB_WIDTH_BIT;
    localparam int unsigned CW    = ROB_WIDTH_BIT + 1;

    logic [DEPTH-1:0]         r_busy;
    logic [DEPTH-1:0]         r_ready;
    logic [DEPTH-1:0]         r_pred;
    logic [DEPTH-1:0]         r_real;
    rob_type_e                r_type   [DEPTH];
    logic [REG_ID_W-1:0]      r_rd     [DEPTH];
    logic [XLEN-1:0]          r_value  [DEPTH];
    logic [XLEN-1:0]          r_alt_pc [DEPTH];
    logic [ROB_WIDTH_BIT-1:0] r_head;
    logic [ROB_WIDTH_BIT-1:0] r_tail;
    logic [CW-1:0]            r_count;

    logic w_issue;
    logic w_wb;
    logic w_commit;
    logic w_flush;
    logic w_hit1;
    logic w_hit2;

    assign rob_full     = (r_count == CW'(DEPTH));
    assign issue_rob_id = r_tail;

    // Fullness is evaluated before this cycle's commit, so a freed slot is not reused in the same cycle.
    assign w_issue  = issue_valid & ~rob_full & ~rob_clear;
    assign w_wb     = wb_valid & r_busy[wb_rob_id];
    assign w_commit = r_busy[r_head] & r_ready[r_head] & ~halt;
    assign w_flush  = w_commit & (r_type[r_head] == ROB_TYPE_BRANCH)
                    & (r_real[r_head] != r_pred[r_head]);

    // Operand queries see a same-cycle CDB result through the bypass.
    assign w_hit1           = wb_valid & (wb_rob_id == get_rob_id1);
    assign w_hit2           = wb_valid & (wb_rob_id == get_rob_id2);
    assign rob_value1_ready = r_busy[get_rob_id1] & (r_ready[get_rob_id1] | w_hit1);
    assign rob_value2_ready = r_busy[get_rob_id2] & (r_ready[get_rob_id2] | w_hit2);
    assign rob_value1       = w_hit1 ? wb_value : r_value[get_rob_id1];
    assign rob_value2       = w_hit2 ? wb_value : r_value[get_rob_id2];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy              <= '0;
            r_ready             <= '0;
            r_pred              <= '0;
            r_real              <= '0;
            r_head              <= '0;
            r_tail              <= '0;
            r_count             <= '0;
            set_reg_id          <= '0;
            set_val             <= '0;
            set_reg_on_rob_id   <= '0;
            commit_store        <= 1'b0;
            commit_store_rob_id <= '0;
            rob_clear           <= 1'b0;
            correct_pc          <= '0;
            halt                <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_type[i]   <= ROB_TYPE_REG;
                r_rd[i]     <= '0;
                r_value[i]  <= '0;
                r_alt_pc[i] <= '0;
            end
        end else if (rdy_in) begin
            set_reg_id          <= '0;
            set_val             <= '0;
            set_reg_on_rob_id   <= '0;
            commit_store        <= 1'b0;
            commit_store_rob_id <= '0;
            rob_clear           <= 1'b0;
            correct_pc          <= '0;

            if (w_flush) begin
                r_busy  <= '0;
                r_ready <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_issue) begin
                    r_busy[r_tail]   <= 1'b1;
                    r_ready[r_tail]  <= (rob_type_e'(issue_type) == ROB_TYPE_EXIT);
                    r_type[r_tail]   <= rob_type_e'(issue_type);
                    r_rd[r_tail]     <= issue_rd;
                    r_pred[r_tail]   <= issue_pred_jump;
                    r_alt_pc[r_tail] <= issue_alt_pc;
                    r_tail           <= r_tail + ROB_WIDTH_BIT'(1);
                end
                if (w_wb) begin
                    r_ready[wb_rob_id] <= 1'b1;
                    r_value[wb_rob_id] <= wb_value;
                    r_real[wb_rob_id]  <= wb_real_jump;
                end
                if (w_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + ROB_WIDTH_BIT'(1);
                end
                r_count <= r_count + CW'(w_issue) - CW'(w_commit);
            end

            // Retirement side effects become visible one cycle after the commit.
            if (w_commit) begin
                unique case (r_type[r_head])
                    ROB_TYPE_REG: begin
                        set_reg_id        <= r_rd[r_head];
                        set_val           <= r_value[r_head];
                        set_reg_on_rob_id <= r_head;
                    end
                    ROB_TYPE_STORE: begin
                        commit_store        <= 1'b1;
                        commit_store_rob_id <= r_head;
                    end
                    ROB_TYPE_BRANCH: begin
                        if (w_flush) begin
                            rob_clear  <= 1'b1;
                            correct_pc <= r_alt_pc[r_head];
                        end
                    end
                    ROB_TYPE_EXIT: begin
                        halt <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
